// File: rtl/demux_tdm_sequencer.sv
// demux_tdm_sequencer: upstream driver for a 1-to-4 demultiplexer.
// Accepts a 4-bit word over VALID/READY, then serialises it onto D while
// stepping S through channels 0..3, each channel held for HOLD cycles.
// A one-cycle DONE pulse (back in IDLE, READY=1) closes every frame.
// Optional build macro DEMUX_TDM_GAP_EN inserts one D=0 gap cycle between
// consecutive channel slots (break-before-make on the demux outputs).
module demux_tdm_sequencer #(
    parameter int HOLD = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] DIN,
    input  logic       VALID,
    output logic       READY,
    output logic       D,
    output logic [1:0] S,
    output logic       BUSY,
    output logic       DONE
);

    // Last value of the 8-bit slot counter within one channel slot.
    localparam logic [7:0] LP_LAST = 8'(HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLOT = 2'd1
`ifdef DEMUX_TDM_GAP_EN
        ,
        ST_GAP  = 2'd2
`endif
    } state_t;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [1:0] r_ch;
    logic [3:0] r_word;
    logic       r_ready;
    logic       r_d;
    logic [1:0] r_s;
    logic       r_busy;
    logic       r_done;

    state_t     w_nxt_state;
    logic [7:0] w_nxt_cnt;
    logic [1:0] w_nxt_ch;
    logic [3:0] w_nxt_word;
    logic       w_frame_end;
    logic       w_accept;
    logic       w_slot_end;
    logic       w_nxt_ready;
    logic       w_nxt_d;
    logic [1:0] w_nxt_s;
    logic       w_nxt_busy;
    logic       w_nxt_done;

    // READY is high exactly while in IDLE, so it doubles as the accept gate.
    assign w_accept   = VALID & r_ready;
    assign w_slot_end = (r_cnt == LP_LAST);

    // State register plus registered outputs; reset aborts any frame in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_ch    <= 2'd0;
            r_ready <= 1'b1;
            r_d     <= 1'b0;
            r_s     <= 2'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_ch    <= w_nxt_ch;
            r_ready <= w_nxt_ready;
            r_d     <= w_nxt_d;
            r_s     <= w_nxt_s;
            r_busy  <= w_nxt_busy;
            r_done  <= w_nxt_done;
        end
    end

    // Latched word holds only data, so it needs no reset.
    always_ff @(posedge CLK) begin
        r_word <= w_nxt_word;
    end

    // Next-state logic: slot timing, channel stepping and frame termination.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_ch    = r_ch;
        w_nxt_word  = r_word;
        w_frame_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_nxt_state = ST_SLOT;
                    w_nxt_cnt   = 8'd0;
                    w_nxt_ch    = 2'd0;
                    w_nxt_word  = DIN;
                end
            end
            ST_SLOT: begin
                if (w_slot_end) begin
                    w_nxt_cnt = 8'd0;
                    if (r_ch == 2'd3) begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_ch    = 2'd0;
                        w_frame_end = 1'b1;
                    end else begin
`ifdef DEMUX_TDM_GAP_EN
                        w_nxt_state = ST_GAP;
`else
                        w_nxt_ch    = r_ch + 2'd1;
`endif
                    end
                end else begin
                    w_nxt_cnt = r_cnt + 8'd1;
                end
            end
`ifdef DEMUX_TDM_GAP_EN
            ST_GAP: begin
                // S keeps the previous channel during the gap; advance on exit.
                w_nxt_state = ST_SLOT;
                w_nxt_cnt   = 8'd0;
                w_nxt_ch    = r_ch + 2'd1;
            end
`endif
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_cnt   = 8'd0;
                w_nxt_ch    = 2'd0;
            end
        endcase
    end

    // Output decode from the upcoming state so every output is registered.
    always_comb begin
        w_nxt_ready = (w_nxt_state == ST_IDLE);
        w_nxt_busy  = ~w_nxt_ready;
        w_nxt_s     = w_nxt_ready ? 2'd0 : w_nxt_ch;
        w_nxt_d     = (w_nxt_state == ST_SLOT) ? w_nxt_word[w_nxt_ch] : 1'b0;
        w_nxt_done  = w_frame_end;
    end

    assign READY = r_ready;
    assign D     = r_d;
    assign S     = r_s;
    assign BUSY  = r_busy;
    assign DONE  = r_done;

endmodule

// File: tb/tb_demux_tdm_sequencer.sv
// Bench for demux_tdm_sequencer: three instances (HOLD=2, 1, 255) share one
// stimulus stream; an arithmetic frame-position model predicts every output.
module tb_demux_tdm_sequencer;

    localparam int H0 = 2;
    localparam int H1 = 1;
    localparam int H2 = 255;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] DIN;
    logic       VALID;
    logic [2:0] rdy, dd, bsy, dn;
    logic [1:0] ss [3];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int         pos [3];
    logic [3:0] wrd [3];
    logic [5:0] cmp_got, cmp_exp;

    demux_tdm_sequencer #(.HOLD(H0)) u0 (.CLK(CLK), .RST(RST), .DIN(DIN), .VALID(VALID),
        .READY(rdy[0]), .D(dd[0]), .S(ss[0]), .BUSY(bsy[0]), .DONE(dn[0]));
    demux_tdm_sequencer #(.HOLD(H1)) u1 (.CLK(CLK), .RST(RST), .DIN(DIN), .VALID(VALID),
        .READY(rdy[1]), .D(dd[1]), .S(ss[1]), .BUSY(bsy[1]), .DONE(dn[1]));
    demux_tdm_sequencer #(.HOLD(H2)) u2 (.CLK(CLK), .RST(RST), .DIN(DIN), .VALID(VALID),
        .READY(rdy[2]), .D(dd[2]), .S(ss[2]), .BUSY(bsy[2]), .DONE(dn[2]));

    always #5 CLK = ~CLK;

    function automatic int hold_of(input int i);
        if (i == 0) return H0;
        if (i == 1) return H1;
        return H2;
    endfunction

    function automatic int frame_len(input int h);
`ifdef DEMUX_TDM_GAP_EN
        return 4 * h + 3;
`else
        return 4 * h;
`endif
    endfunction

    // Expected {ready,busy,done,s[1:0],d} at frame position p (-1 = idle, len = DONE cycle).
    function automatic logic [5:0] model_out(input int h, input int p, input logic [3:0] w);
        int seg, ch, off;
        if (p < 0) return 6'b100000;
        if (p == frame_len(h)) return 6'b101000;
`ifdef DEMUX_TDM_GAP_EN
        seg = h + 1;
`else
        seg = h;
`endif
        ch  = p / seg;
        off = p % seg;
        return {1'b0, 1'b1, 1'b0, 2'(ch), (off >= h) ? 1'b0 : w[ch]};
    endfunction

    function automatic logic [5:0] out_of(input int i);
        return {rdy[i], bsy[i], dn[i], ss[i], dd[i]};
    endfunction

    // Model: track each instance's position inside its frame.
    always @(posedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            if (RST) pos[i] <= -1;
            else if (pos[i] < 0 || pos[i] == frame_len(hold_of(i))) begin
                if (VALID) begin
                    pos[i] <= 0;
                    wrd[i] <= DIN;
                end else begin
                    pos[i] <= -1;
                end
            end else begin
                pos[i] <= pos[i] + 1;
            end
        end
    end

    // Compare every instance against the model each cycle.
    always @(negedge CLK) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                cmp_exp = model_out(hold_of(i), pos[i], wrd[i]);
                cmp_got = out_of(i);
                checks++;
                if (cmp_got !== cmp_exp) begin
                    errors++;
                    $display("FAIL model_dut%0d pos=%0d rdy/busy/done/s/d got=%b required=%b",
                             i, pos[i], cmp_got, cmp_exp);
                end
            end
        end
    end

    task automatic lit(input string name, input logic [5:0] got, input logic [5:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b required=%b", name, got, want);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST   = 1'b1;
        VALID = 1'b0;
        @(negedge CLK);
        RST   = 1'b0;
    endtask

    // Hand-derived output sequences {ready,busy,done,s,d}.
`ifdef DEMUX_TDM_GAP_EN
    localparam int NA = 12;
    localparam int NB = 16;
    logic [5:0] tab_a [NA] = '{6'b010000, 6'b010000, 6'b010000, 6'b010011, 6'b010011, 6'b010010,
                               6'b010100, 6'b010100, 6'b010100, 6'b010111, 6'b010111, 6'b101000};
    logic [5:0] tab_b [NB] = '{6'b010001, 6'b010000, 6'b010011, 6'b010010, 6'b010101, 6'b010100,
                               6'b010111, 6'b101000, 6'b010001, 6'b010000, 6'b010010, 6'b010010,
                               6'b010100, 6'b010100, 6'b010110, 6'b101000};
    logic [5:0] mid_a = 6'b010000;
`else
    localparam int NA = 9;
    localparam int NB = 10;
    logic [5:0] tab_a [NA] = '{6'b010000, 6'b010000, 6'b010011, 6'b010011, 6'b010100,
                               6'b010100, 6'b010111, 6'b010111, 6'b101000};
    logic [5:0] tab_b [NB] = '{6'b010001, 6'b010011, 6'b010101, 6'b010111, 6'b101000,
                               6'b010001, 6'b010010, 6'b010100, 6'b010110, 6'b101000};
    logic [5:0] mid_a = 6'b010011;
`endif

    initial begin
        int n;
        int lc;
        RST   = 1'b1;
        VALID = 1'b0;
        DIN   = 4'd0;
        repeat (2) @(negedge CLK);
        RST    = 1'b0;
        chk_en = 1'b1;

        // Reset values on the first cycle after release.
        @(negedge CLK);
        lit("reset_dut0", out_of(0), 6'b100000);
        lit("reset_dut1", out_of(1), 6'b100000);
        lit("reset_dut2", out_of(2), 6'b100000);

        // Single frame, HOLD=2, word 1010.
        DIN   = 4'b1010;
        VALID = 1'b1;
        for (int k = 0; k < NA; k++) begin
            @(negedge CLK);
            if (k == 0) VALID = 1'b0;
            lit($sformatf("single_frame_c%0d", k + 1), out_of(0), tab_a[k]);
        end

        // Back-to-back, HOLD=1, VALID held high: 1111 then 0001.
        do_reset();
        DIN   = 4'b1111;
        VALID = 1'b1;
        for (int k = 0; k < NB; k++) begin
            @(negedge CLK);
            if (k == 0) DIN = 4'b0001;
            lit($sformatf("back_to_back_c%0d", k + 1), out_of(1), tab_b[k]);
        end
        VALID = 1'b0;

        // Mid-frame DIN change and VALID pulse must not disturb word 0110.
        do_reset();
        DIN   = 4'b0110;
        VALID = 1'b1;
        @(negedge CLK);
        VALID = 1'b0;
        @(negedge CLK);
        DIN   = 4'b0000;
        VALID = 1'b1;
        @(negedge CLK);
        VALID = 1'b0;
        lit("midframe_c3", out_of(0), mid_a);
        repeat (12) @(negedge CLK);

        // Reset while channel 2 is being driven, then a clean 0100 frame.
        do_reset();
        DIN   = 4'b1011;
        VALID = 1'b1;
        @(negedge CLK);
        VALID = 1'b0;
        n = 0;
        while (ss[0] != 2'd2 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        lit("wait_s10", {4'b0, ss[0]}, 6'd2);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        lit("abort_dut0", out_of(0), 6'b100000);
        DIN   = 4'b0100;
        VALID = 1'b1;
        @(negedge CLK);
        VALID = 1'b0;
        repeat (14) @(negedge CLK);

        // HOLD=255 frame: DONE must land exactly one cycle after the last slot.
        do_reset();
        DIN   = 4'($urandom);
        VALID = 1'b1;
        lc = frame_len(H2) + 1;
        for (int k = 1; k <= lc; k++) begin
            @(negedge CLK);
            if (k == lc) lit("hold255_done", {5'b0, dn[2]}, 6'd1);
            VALID = 1'($urandom_range(0, 1));
            DIN   = 4'($urandom);
        end

        // Randomised traffic with occasional resets.
        do_reset();
        repeat (2000) begin
            @(negedge CLK);
            RST   = ($urandom_range(0, 299) == 0);
            VALID = 1'($urandom_range(0, 1));
            DIN   = 4'($urandom);
        end

        @(negedge CLK);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_tdm_sequencer.md
Name: demux_tdm_sequencer

Overview:
- Upstream driver for the 1-to-4 demultiplexer stage. Accepts a 4-bit word through a VALID/READY handshake.
- Time-multiplexes the word onto the single data line D while stepping the select S through channels 0..3, each held for HOLD cycles. The downstream demux then routes bit k to output Y[k].
- Outputs D and S connect directly to the demux D and S inputs.

Parameters:
- HOLD, 2, cycles each channel slot is driven; legal range 1..255; 8-bit slot counter.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous, active-high reset
- DIN  input  4  word to distribute; DIN[k] goes to channel k
- VALID  input  1  DIN is valid this cycle
- READY  output  1  block can accept a word this cycle
- D  output  1  serial data to the demux D input
- S  output  2  channel select to the demux S input
- BUSY  output  1  frame in progress
- DONE  output  1  one-cycle pulse after the last slot of a frame

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST), sampled only on the rising CLK edge.
- All outputs are registered. Reset values: READY=1, D=0, S=2'b00, BUSY=0, DONE=0. Internal state goes to IDLE; slot counter and channel index are cleared.
- States:
  - IDLE: READY=1, D=0, S=00, BUSY=0.
  - SLOT: drives the current channel.
  - GAP: present only with the optional feature.
- Accept: VALID=1 and READY=1 at a rising edge.
  - DIN is latched into an internal 4-bit register.
  - Next cycle: state=SLOT, S=00, D=DIN[0], READY=0, BUSY=1.
- SLOT:
  - S and D are held for exactly HOLD cycles.
  - Then S increments and D takes the latched bit for the new channel.
  - Channel order is always 0,1,2,3.
- After channel 3 completes its HOLD cycles, there is one cycle with DONE=1, READY=1, BUSY=0, D=0, S=00 (state=IDLE). DONE is 0 in every other cycle.
- Latency from accept edge to first slot output: 1 cycle. Frame occupancy: 4*HOLD cycles, plus the DONE/IDLE cycle.
- Back-to-back frames: VALID=1 during the DONE cycle is accepted. The next frame's S=00 slot starts in the following cycle. Minimum period is 4*HOLD+1 cycles.
- While BUSY=1, READY=0. VALID and DIN are ignored, and DIN changes do not affect the frame in flight.
- VALID held high in IDLE: one word is accepted per frame only.
- RST=1 mid-frame: the frame is aborted at that edge and all outputs take reset values. No DONE pulse is produced for the aborted frame.
- RST and VALID high together: reset wins and nothing is accepted.
- HOLD=1: S changes every cycle. The slot counter wraps correctly at HOLD=255 with no skipped or extra cycle.

Optional Feature:
- Macro: DEMUX_TDM_GAP_EN.
- Defined:
  - Between consecutive slots (0→1, 1→2, 2→3), insert one GAP cycle with D=0 and S holding the previous channel.
  - This gives a break-before-make on the demux outputs.
  - No GAP after channel 3; the DONE cycle follows directly.
  - Frame occupancy becomes 4*HOLD+3 cycles.
  - RST during GAP aborts as above.
- Undefined: the GAP state and its logic are not compiled in, and slots are contiguous.

Test Plan:
- Reset: RST=1 for 2 cycles, then release → READY=1, D=0, S=00, BUSY=0, DONE=0 on the first cycle after release.
- Single frame, HOLD=2, DIN=4'b1010 accepted at edge t0:
  - t1-t2: S=00, D=0
  - t3-t4: S=01, D=1
  - t5-t6: S=10, D=0
  - t7-t8: S=11, D=1
  - t9: DONE=1, READY=1
- Back-to-back, HOLD=1, DIN=4'b1111 then 4'b0001 with VALID held high → second frame starts the cycle after DONE. Second frame drives D=1,0,0,0 on S=0,1,2,3. Period is 5 cycles.
- DIN changed to 4'b0000 and VALID pulsed mid-frame (DIN=4'b0110 in flight) → the frame still outputs D=0,1,1,0. No second accept until DONE.
- RST asserted during the S=10 slot → next cycle READY=1, S=00, D=0, and no DONE pulse. A new frame with DIN=4'b0100 then runs normally.
- With DEMUX_TDM_GAP_EN, HOLD=1, DIN=4'b1111:
  - Cycle sequence (S,D): (00,1), (00,0), (01,1), (01,0), (10,1), (10,0), (11,1), then DONE.
  - Frame occupancy is 7 cycles.
